// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// the fixed RAM access size and request-legality helpers.
package lsu_pkg;

    // RV32I load/store funct3 encodings (stores use the B/H/W codes)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // The RAM d-port only ever does full-word transfers
    localparam logic [2:0] MEM_SIZE_WORD = 3'b010;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        RESP
    } lsu_state_e;

    // funct3 values that have no meaning for the given direction
    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        if (we) begin
            return f3 > F3_W;
        end
        return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    endfunction

    // Halfwords need an even address, words a 4-byte aligned address
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
        return ((f3[1:0] == 2'b01) && addr_lo[0]) ||
               ((f3[1:0] == 2'b10) && (addr_lo != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
//   rdata        : word read from the RAM
//   wdata        : right-aligned store data (only byte/half stores need it)
//   addr_lo      : byte offset inside the word
//   funct3       : access type
//   load_val_c   : lane extracted and sign/zero-extended
//   store_word_c : rdata with the addressed byte/half replaced by wdata
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [15:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    output logic [31:0] load_val_c,
    output logic [31:0] store_word_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Load extract
    always_comb begin
        byte_sel   = rdata[7:0];
        load_val_c = '0;
        case (addr_lo)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_B:    load_val_c = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   load_val_c = {24'h000000, byte_sel};
            F3_H:    load_val_c = {{16{half_sel[15]}}, half_sel};
            F3_HU:   load_val_c = {16'h0000, half_sel};
            F3_W:    load_val_c = rdata;
            default: load_val_c = '0;
        endcase
    end

    // Store merge: only the addressed lane changes, others are preserved
    always_comb begin
        store_word_c = rdata;
        if (funct3[1:0] == 2'b00) begin
            case (addr_lo)
                2'd0:    store_word_c[7:0]   = wdata[7:0];
                2'd1:    store_word_c[15:8]  = wdata[7:0];
                2'd2:    store_word_c[23:16] = wdata[7:0];
                default: store_word_c[31:24] = wdata[7:0];
            endcase
        end else if (addr_lo[1]) begin
            store_word_c[31:16] = wdata;
        end else begin
            store_word_c[15:0] = wdata;
        end
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store initiator for the core RAM data port. Accepts one request at a
// time, checks legality/alignment/range, performs sub-word stores as
// read-modify-write and returns extended load data.
//   clk, rst_n                 : clock, synchronous active-low reset
//   req_valid/req_ready        : request handshake (ready only in IDLE)
//   req_we/funct3/addr/wdata   : request payload
//   resp_valid/err/rdata       : one-cycle completion pulse
//   mem_we/size/addr/wdata     : RAM d-port command, mem_rdata one cycle later
module lsu_mem_port
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W      = 14,
    parameter bit          CHECK_RANGE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    lsu_state_e        state;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [15:0]       wdata_q;
    logic [31:0]       merge_q;
    logic              mem_we_q;

    logic              out_of_range_c;
    logic              req_err_c;
    logic [31:0]       load_val_c;
    logic [31:0]       store_word_c;

    // Request legality, evaluated on the live request in IDLE
    assign out_of_range_c = CHECK_RANGE && ((req_addr >> ADDR_W) != 32'd0);
    assign req_err_c      = f3_illegal(req_we, req_funct3) ||
                            misaligned(req_funct3, req_addr[1:0]) ||
                            out_of_range_c;

    lsu_align u_align (
        .rdata        (mem_rdata),
        .wdata        (wdata_q),
        .addr_lo      (addr_q[1:0]),
        .funct3       (funct3_q),
        .load_val_c   (load_val_c),
        .store_word_c (store_word_c)
    );

    // Write enable is killed the instant reset asserts so an abandoned RMW never lands
    assign mem_we    = mem_we_q & rst_n;
    assign mem_size  = MEM_SIZE_WORD;
    assign mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign mem_wdata = merge_q;

    // Sequencer: one state per cycle, all outputs registered on transitions
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            funct3_q   <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            mem_we_q   <= 1'b0;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            mem_we_q   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        addr_q    <= req_addr[ADDR_W-1:0];
                        we_q      <= req_we;
                        funct3_q  <= req_funct3;
                        wdata_q   <= req_wdata[15:0];
                        merge_q   <= req_wdata;
                        req_ready <= 1'b0;
                        if (req_err_c) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            state      <= RESP;
                        end else if (req_we && (req_funct3 == F3_W)) begin
                            mem_we_q <= 1'b1;
                            state    <= WRITE;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ: state <= WAIT;
                WAIT: begin
                    if (we_q) begin
                        merge_q  <= store_word_c;
                        mem_we_q <= 1'b1;
                        state    <= WRITE;
                    end else begin
                        resp_rdata <= load_val_c;
                        resp_valid <= 1'b1;
                        state      <= RESP;
                    end
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule
